// File: rtl/ts_pkg.sv
// Shared constants and types for the serial-to-parallel TS front end.
// Pure definitions; no logic, no latency.
// No flow control; consumers import what they need.
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
    localparam int         TS_PKT_LEN_188 = 188;
    localparam int         TS_PKT_LEN_204 = 204;

    // Packet alignment state: hunting for a sync strobe, or tracking packets.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Bits needed to index every bit position of one packet.
    function automatic int ts_bcnt_w(input int pkt_len);
        return $clog2(pkt_len * 8);
    endfunction

endpackage

// File: rtl/ts_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Latency: count visible one clock after the increment strobe.
// No backpressure; an increment at saturation is silently absorbed.
module ts_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on each strobe until every bit is set, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ts_ser2par.sv
// Serial TS to PAR_W-bit parallel words, packet aligned on sync; optional stats via TS_SER2PAR_STATS_EN.
// Latency: word strobe one clock after its last serial bit; err_sync one clock after the offending bit.
// No backpressure: the serial source cannot be stalled, gaps are expressed with ts_ser_i_valid=0.
module ts_ser2par
    import ts_pkg::*;
#(
    parameter int         PAR_W     = 8,
    parameter int         PKT_LEN   = TS_PKT_LEN_188,
    parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
    parameter int         CNT_W     = 16
) (
    input  logic             ts_ser_i_clk,
    input  logic             rst_n,
    input  logic             ts_ser_i_data,
    input  logic             ts_ser_i_sync,
    input  logic             ts_ser_i_valid,
    output logic [PAR_W-1:0] ts_par_o_data,
    output logic             ts_par_o_sync,
    output logic             ts_par_o_valid,
    output logic             locked,
    output logic             err_sync
`ifdef TS_SER2PAR_STATS_EN
    ,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int PKT_BITS = PKT_LEN * 8;
    localparam int BCNT_W   = ts_bcnt_w(PKT_LEN);
    localparam int WSEL_W   = $clog2(PAR_W);

    // Reject configurations the word slicing and counters cannot support.
    if (!((PAR_W == 8) || (PAR_W == 16) || (PAR_W == 32)) ||
        !((PKT_LEN == TS_PKT_LEN_188) || (PKT_LEN == TS_PKT_LEN_204)) ||
        ((PKT_BITS % PAR_W) != 0) || (CNT_W < 1)) begin : g_bad_param
        $error("ts_ser2par: illegal parameter combination");
    end

    lock_state_t       state;
    logic [BCNT_W-1:0] bcnt;
    logic [PAR_W-1:0]  sr;

    logic [PAR_W-1:0]  sr_nxt;
    logic              hunt_start;
    logic              early_sync;
    logic              miss_sync;
    logic              shift_ok;
    logic              byte_bad;
    logic              word_done;
    logic              pkt_last;
    logic              err_evt;

    // Classify the incoming bit; the error cases are mutually exclusive by construction.
    always_comb begin
        sr_nxt     = {sr[PAR_W-2:0], ts_ser_i_data};
        hunt_start = ts_ser_i_valid && (state == HUNT) && ts_ser_i_sync;
        early_sync = ts_ser_i_valid && (state == LOCKED) && ts_ser_i_sync && (bcnt != '0);
        miss_sync  = ts_ser_i_valid && (state == LOCKED) && !ts_ser_i_sync && (bcnt == '0);
        shift_ok   = ts_ser_i_valid && (state == LOCKED) && !early_sync && !miss_sync;
        // Bit 7 completes the sync byte; a bad one kills the packet before any word leaves.
        byte_bad   = shift_ok && (bcnt == BCNT_W'(7)) && (sr_nxt[7:0] != SYNC_BYTE);
        word_done  = shift_ok && !byte_bad && (bcnt[WSEL_W-1:0] == '1);
        pkt_last   = (bcnt == BCNT_W'(PKT_BITS - 1));
        err_evt    = early_sync || miss_sync || byte_bad;
    end

    // Alignment FSM with registered word, sync and error outputs.
    always_ff @(posedge ts_ser_i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HUNT;
            bcnt           <= '0;
            sr             <= '0;
            ts_par_o_data  <= '0;
            ts_par_o_sync  <= 1'b0;
            ts_par_o_valid <= 1'b0;
            err_sync       <= 1'b0;
        end else begin
            ts_par_o_valid <= 1'b0;
            ts_par_o_sync  <= 1'b0;
            err_sync       <= err_evt;
            if (ts_ser_i_valid) begin
                // Shifting in HUNT is harmless: stale bits leave before a word completes.
                sr <= sr_nxt;
                case (state)
                    HUNT: begin
                        if (hunt_start) begin
                            state <= LOCKED;
                            bcnt  <= BCNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (early_sync) begin
                            bcnt <= BCNT_W'(1);
                        end else if (miss_sync || byte_bad) begin
                            state <= HUNT;
                            bcnt  <= '0;
                        end else begin
                            bcnt <= pkt_last ? '0 : bcnt + 1'b1;
                            if (word_done) begin
                                ts_par_o_data  <= sr_nxt;
                                ts_par_o_valid <= 1'b1;
                                ts_par_o_sync  <= (bcnt == BCNT_W'(PAR_W - 1));
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                        bcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef TS_SER2PAR_STATS_EN
    ts_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk   (ts_ser_i_clk),
        .rst_n (rst_n),
        .inc   (word_done && pkt_last),
        .cnt   (pkt_cnt)
    );

    ts_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (ts_ser_i_clk),
        .rst_n (rst_n),
        .inc   (err_evt),
        .cnt   (err_cnt)
    );
`endif

endmodule

// File: doc/ts_ser2par.md
Name: ts_ser2par

Overview:
- Parametrised serial-to-parallel transport-stream converter.
- Sits between a serial TS interface (1-bit data, sync, valid) and the parallel TS interfaces of the processing chain.
- Packet-aligned: locks on the sync strobe, checks the sync byte value, and packs bits MSB-first into PAR_W-bit words (8, 16 or 32).
- Tracks packet boundaries and reports loss of alignment.

Parameters:
- PAR_W, 8: output word width; legal values 8, 16, 32.
- PKT_LEN, 188: packet length in bytes; legal values 188, 204. PKT_LEN*8 is divisible by PAR_W.
- SYNC_BYTE, 8'h47: expected first byte of every packet.
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- ts_ser_i_clk, input, 1: the single clock; serial TS bit clock. All outputs are synchronous to it.
- rst_n, input, 1: asynchronous active-low reset; deassertion is synchronous to ts_ser_i_clk.
- ts_ser_i_data, input, 1: serial bit, MSB of each byte first.
- ts_ser_i_sync, input, 1: marks the first bit of a packet (MSB of the sync byte).
- ts_ser_i_valid, input, 1: qualifies data and sync.
- ts_par_o_data, output, PAR_W: assembled word; first-received byte in bits [PAR_W-1:PAR_W-8].
- ts_par_o_sync, output, 1: high with the first word of a packet.
- ts_par_o_valid, output, 1: one-cycle strobe per word.
- locked, output, 1: high while in LOCKED.
- err_sync, output, 1: one-cycle pulse on any alignment error.

Behaviour:
- Reset values: all outputs 0; state HUNT; bit counter 0; shift register 0.
- A bit is consumed only when ts_ser_i_valid=1. Gaps (valid=0) freeze all state. ts_ser_i_sync is ignored when valid=0.
- Bit counter bcnt counts 0..PKT_LEN*8-1 and wraps to 0 at packet end.
- HUNT state:
  - Bits are discarded; no words are emitted.
  - Bit with sync=1 and valid=1: that bit is bit 0, bcnt becomes 1, state goes to LOCKED. locked goes high the next cycle.
- LOCKED state:
  - Each valid bit shifts into the shift register; bcnt increments.
  - When bit 7 of a packet (bcnt=7) is consumed, the assembled byte is compared with SYNC_BYTE.
    - Mismatch: err_sync pulses the next cycle; state goes to HUNT; the partial word is dropped.
    - With PAR_W=8, a mismatched sync byte is never emitted.
  - Sync=1 at bcnt≠0 (early or misplaced sync):
    - err_sync pulses; the partial word is dropped.
    - The bit is taken as bit 0 of a new packet; bcnt becomes 1; state stays LOCKED.
  - Sync=0 at bcnt=0 (missing sync at the expected packet start):
    - err_sync pulses; state goes to HUNT; the bit is discarded.
- Word output:
  - When the PAR_W-th bit of a word is consumed, the word registers onto ts_par_o_data.
  - ts_par_o_valid is high exactly the next cycle (latency 1 clock after the last bit).
  - ts_par_o_sync=1 with the word starting at bcnt=0.
  - ts_par_o_data holds its value until the next word.
  - PKT_LEN*8/PAR_W words per packet, e.g. 47 for 188 bytes at 32 bits.
- Simultaneous events: a sync bit that completes no word produces no output.
- rst_n asserted mid-packet: immediate return to reset values; any partial word is lost.

Optional Feature:
- Macro: TS_SER2PAR_STATS_EN.
- Defined: adds two outputs.
  - pkt_cnt [CNT_W]: increments when the last word of a packet is emitted.
  - err_cnt [CNT_W]: increments on each err_sync pulse.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package/header ts_pkg.vh:
  - TS_SYNC_BYTE (8'h47).
  - TS_PKT_LEN_188 and TS_PKT_LEN_204.
  - Lock state encodings: HUNT=1'b0, LOCKED=1'b1.
  - Helper macro for the bit-counter width: clog2 of PKT_LEN*8.
- One sub-module: ts_sat_counter (CNT_W-bit saturating counter), instantiated twice when TS_SER2PAR_STATS_EN is defined.

Test Plan:
- PAR_W=8, 188-byte packet 47,00,01..BA sent MSB-first with sync on the first bit:
  - 188 valid strobes; first word 8'h47 with ts_par_o_sync=1; locked=1; err_sync never pulses.
- PAR_W=32, same packet with valid toggling 1,0,1,0:
  - 47 words; first word 32'h47000102; valid strobe 1 cycle after the 32nd bit; no output during gaps.
- Sync byte 8'h46 after lock:
  - err_sync pulses once; locked drops; no word emitted for that packet (PAR_W=8).
- Sync at bcnt=100:
  - err_sync pulses; partial word dropped; the next word carries ts_par_o_sync=1.
- Missing sync at a packet boundary:
  - err_sync pulses; state HUNT; no further words until the next sync.
- rst_n pulsed low at bcnt=500; with stats enabled, 3 good packets then 1 bad packet:
  - After reset, all outputs are 0.
  - In the second run, pkt_cnt=3 and err_cnt=1.
